// File: rtl/instr_field_decoder.sv
// Decode-side front end: a 2-entry skid buffer that splits MIPS words into registered fields.
// Optional macro ILLEGAL_OP_DETECT_EN builds unsupported-opcode/funct detection on illegal_op.
module instr_field_decoder #(
  parameter int unsigned PC_W       = 32,
  parameter logic [5:0]  J_OPCODE   = 6'h02,
  parameter logic [5:0]  JAL_OPCODE = 6'h03
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     immediate16,
  output logic [25:0]     immediate26,
  output logic            ext_select,
  output logic [PC_W-1:0] pc_out,
  output logic            illegal_op
);

  logic            head_v, skid_v;
  logic [31:0]     head_w, skid_w;
  logic [PC_W-1:0] head_pc, skid_pc;
  logic            head_ext;

  logic            accept, consume;
  logic            load_from_skid, load_from_in, to_skid;
  logic [31:0]     load_w;
  logic [PC_W-1:0] load_pc;

  always_comb begin
    accept         = in_valid & in_ready;
    consume        = head_v & out_ready;
    load_from_skid = consume & skid_v;
    load_from_in   = accept & (~head_v | consume);
    to_skid        = accept & head_v & ~consume;
    load_w         = load_from_skid ? skid_w  : instr;
    load_pc        = load_from_skid ? skid_pc : pc_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_v   <= 1'b0;
      skid_v   <= 1'b0;
      head_w   <= '0;
      head_pc  <= '0;
      head_ext <= 1'b0;
      skid_w   <= '0;
      skid_pc  <= '0;
    end else if (flush) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      // Head only rewrites on a load, so fields hold their last value while idle.
      if (load_from_skid || load_from_in) begin
        head_w   <= load_w;
        head_pc  <= load_pc;
        head_ext <= (load_w[31:26] == J_OPCODE) || (load_w[31:26] == JAL_OPCODE);
      end
      head_v <= load_from_skid | load_from_in | (head_v & ~consume);
      if (to_skid) begin
        skid_w  <= instr;
        skid_pc <= pc_in;
      end
      skid_v <= to_skid | (skid_v & ~load_from_skid);
    end
  end

  assign in_ready    = ~skid_v;
  assign out_valid   = head_v;
  assign opcode      = head_w[31:26];
  assign rs          = head_w[25:21];
  assign rt          = head_w[20:16];
  assign rd          = head_w[15:11];
  assign shamt       = head_w[10:6];
  assign funct       = head_w[5:0];
  assign immediate16 = head_w[15:0];
  assign immediate26 = head_w[25:0];
  assign ext_select  = head_ext;
  assign pc_out      = head_pc;

`ifdef ILLEGAL_OP_DETECT_EN
  function automatic logic illegal_of(input logic [31:0] w);
    logic bad;
    bad = 1'b1;
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h00, 6'h02, 6'h08, 6'h20, 6'h21,
          6'h22, 6'h23, 6'h24, 6'h25, 6'h2A: bad = 1'b0;
          default:                           bad = 1'b1;
        endcase
      end
      6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
      6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: bad = 1'b0;
      default:                           bad = 1'b1;
    endcase
    return bad;
  endfunction

  logic head_ill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ill <= 1'b0;
    end else if (!flush && (load_from_skid || load_from_in)) begin
      head_ill <= illegal_of(load_w);
    end
  end

  assign illegal_op = head_ill;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
